// File: rtl/esm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// esm_pkg : shared sizing and slot-state encoding for the ESM issue scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
package esm_pkg;

  localparam int BS_DEFAULT   = 16;
  localparam int IDXW_DEFAULT = $clog2(BS_DEFAULT);

  typedef enum logic [1:0] {
    SLOT_FREE   = 2'b00,
    SLOT_WAIT   = 2'b01,
    SLOT_ISSUED = 2'b10
  } slot_state_e;

endpackage
`default_nettype wire

// File: rtl/esm_rr_picker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// esm_rr_picker : rotating priority encoder, first request at or after base_i
// Rev 1.0
// ----------------------------------------------------------------------------
module esm_rr_picker #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] base_i,
  output logic         valid_o,
  output logic [W-1:0] index_o
);

  logic [W-1:0] cand;

  // Scan from the farthest offset down so the nearest hit wins; N is a power
  // of two, so the W-bit addition wraps naturally.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = base_i + W'(k);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        index_o = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/esm_issue_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// esm_issue_scheduler : slot allocation, dependency tracking, round-robin issue
// Rev 1.0
// ----------------------------------------------------------------------------
module esm_issue_scheduler
  import esm_pkg::*;
#(
  parameter  int BS   = BS_DEFAULT,
  localparam int IDXW = $clog2(BS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_valid,
  output logic            alloc_ready,
  output logic [IDXW-1:0] alloc_index,
  input  logic [BS-1:0]   alloc_dep,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [IDXW-1:0] issue_index,
  input  logic            complete_valid,
  input  logic [IDXW-1:0] complete_index,
  input  logic            flush,
  output logic [IDXW:0]   occupancy
);

  localparam logic [BS-1:0] c_one = {{(BS-1){1'b0}}, 1'b1};

  slot_state_e     state_q [BS];
  slot_state_e     state_d [BS];
  logic [BS-1:0]   dep_q   [BS];
  logic [BS-1:0]   dep_d   [BS];
  logic [IDXW-1:0] rr_q, rr_d;

  logic [BS-1:0] w_free, w_ready;
  logic [BS-1:0] w_cv_col, w_comp_col;
  logic          w_comp_ok, w_alloc_fire, w_issue_fire;

  always_comb begin
    w_free      = '0;
    w_ready     = '0;
    alloc_index = '0;
    occupancy   = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      w_free[i]  = (state_q[i] == SLOT_FREE);
      w_ready[i] = (state_q[i] == SLOT_WAIT) && (dep_q[i] == '0);
      if (w_free[i]) alloc_index = IDXW'(i);
    end
    for (int i = 0; i < BS; i++) begin
      occupancy = occupancy + {{IDXW{1'b0}}, ~w_free[i]};
    end
  end

  assign alloc_ready = |w_free;

  esm_rr_picker #(
    .N (BS),
    .W (IDXW)
  ) u_picker (
    .req_i   (w_ready),
    .base_i  (rr_q),
    .valid_o (issue_valid),
    .index_o (issue_index)
  );

  assign w_alloc_fire = alloc_valid & alloc_ready;
  assign w_issue_fire = issue_valid & issue_ready;
  assign w_comp_ok    = complete_valid && (state_q[complete_index] == SLOT_ISSUED);
  // A new row never keeps a bit for a producer finishing this very cycle.
  assign w_cv_col     = complete_valid ? (c_one << complete_index) : '0;
  assign w_comp_col   = w_comp_ok ? (c_one << complete_index) : '0;

  always_comb begin
    state_d = state_q;
    dep_d   = dep_q;
    rr_d    = rr_q;
    if (flush) begin
      for (int i = 0; i < BS; i++) begin
        state_d[i] = SLOT_FREE;
        dep_d[i]   = '0;
      end
      rr_d = '0;
    end else begin
      for (int i = 0; i < BS; i++) begin
        dep_d[i] = dep_q[i] & ~w_comp_col;
      end
      if (w_comp_ok) state_d[complete_index] = SLOT_FREE;
      if (w_issue_fire) begin
        state_d[issue_index] = SLOT_ISSUED;
        rr_d                 = issue_index + 1'b1;
      end
      if (w_alloc_fire) begin
        state_d[alloc_index] = SLOT_WAIT;
        dep_d[alloc_index]   = alloc_dep & ~w_free & ~(c_one << alloc_index) & ~w_cv_col;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BS; i++) begin
        state_q[i] <= SLOT_FREE;
        dep_q[i]   <= '0;
      end
      rr_q <= '0;
    end else begin
      state_q <= state_d;
      dep_q   <= dep_d;
      rr_q    <= rr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_esm_issue_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_esm_issue_scheduler : directed self-checking bench for esm_issue_scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_esm_issue_scheduler;

  localparam int BS   = 16;
  localparam int IDXW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            alloc_valid, alloc_ready;
  logic [IDXW-1:0] alloc_index;
  logic [BS-1:0]   alloc_dep;
  logic            issue_valid, issue_ready;
  logic [IDXW-1:0] issue_index;
  logic            complete_valid;
  logic [IDXW-1:0] complete_index;
  logic            flush;
  logic [IDXW:0]   occupancy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  esm_issue_scheduler #(.BS(BS)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_index    (alloc_index),
    .alloc_dep      (alloc_dep),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_index    (issue_index),
    .complete_valid (complete_valid),
    .complete_index (complete_index),
    .flush          (flush),
    .occupancy      (occupancy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid    = 1'b0;
    alloc_dep      = '0;
    issue_ready    = 1'b0;
    complete_valid = 1'b0;
    complete_index = '0;
    flush          = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic alloc(input logic [BS-1:0] dep, input int exp_idx);
    check("alloc_ready", alloc_ready, 1);
    check("alloc_index", alloc_index, exp_idx);
    alloc_valid = 1'b1;
    alloc_dep   = dep;
    tick();
    alloc_valid = 1'b0;
    alloc_dep   = '0;
  endtask

  task automatic issue(input int exp_idx);
    check("issue_valid", issue_valid, 1);
    check("issue_index", issue_index, exp_idx);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
  endtask

  task automatic complete(input int idx);
    complete_valid = 1'b1;
    complete_index = idx[IDXW-1:0];
    tick();
    complete_valid = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_alloc_index", alloc_index, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_issue_index", issue_index, 0);
    check("rst_occupancy", occupancy, 0);

    // dependency chain 0 <- 1 <- 2
    alloc(16'h0000, 0);
    alloc(16'h0001, 1);
    alloc(16'h0002, 2);
    check("chain_occ", occupancy, 3);
    issue(0);
    check("chain_blocked1", issue_valid, 0);
    complete(0);
    issue(1);
    check("chain_blocked2", issue_valid, 0);
    complete(1);
    issue(2);
    do_flush();

    // fill the buffer, then free slot 5
    for (int k = 0; k < BS; k++) alloc('0, k);
    check("full_ready", alloc_ready, 0);
    check("full_occ", occupancy, 16);
    check("full_index", alloc_index, 0);
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    check("full_ignore_occ", occupancy, 16);
    for (int k = 0; k < 6; k++) issue(k);
    complete_valid = 1'b1;
    complete_index = 4'd5;
    #1 check("free_same_cycle", alloc_ready, 0);
    tick();
    complete_valid = 1'b0;
    check("free_ready", alloc_ready, 1);
    check("free_index", alloc_index, 5);
    check("free_occ", occupancy, 15);
    do_flush();

    // round-robin wrap after slot 15
    for (int k = 0; k < BS; k++) alloc('0, k);
    for (int k = 0; k < BS; k++) issue(k);
    check("rr_drained", issue_valid, 0);
    complete(0);
    complete(3);
    alloc('0, 0);
    alloc('0, 3);
    issue(0);
    issue(3);
    do_flush();

    // alloc racing completion of its producer; complete aimed at a WAIT slot
    for (int k = 0; k < 5; k++) alloc('0, k);
    for (int k = 0; k < 5; k++) issue(k);
    check("race_index", alloc_index, 5);
    alloc_valid    = 1'b1;
    alloc_dep      = 16'h0010;
    complete_valid = 1'b1;
    complete_index = 4'd4;
    tick();
    idle();
    check("race_ready", issue_valid, 1);
    check("race_issue_index", issue_index, 5);
    check("race_occ", occupancy, 5);
    alloc(16'h0020, 4);
    complete(5);
    check("wait_cmp_occ", occupancy, 6);
    check("wait_cmp_valid", issue_valid, 1);
    issue(5);
    check("wait_cmp_dep_kept", issue_valid, 0);

    // flush beats simultaneous alloc/issue/complete
    alloc_valid    = 1'b1;
    issue_ready    = 1'b1;
    complete_valid = 1'b1;
    complete_index = 4'd5;
    flush          = 1'b1;
    tick();
    idle();
    check("flush_occ", occupancy, 0);
    check("flush_issue_valid", issue_valid, 0);
    check("flush_alloc_index", alloc_index, 0);
    alloc('0, 0);
    alloc('0, 1);
    check("post_flush_rr", issue_index, 0);

    // asynchronous reset between edges
    check("pre_rst_valid", issue_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_issue_valid", issue_valid, 0);
    check("async_occ", occupancy, 0);
    check("async_alloc_ready", alloc_ready, 1);
    #1 rst = 1'b0;
    tick();
    check("post_rst_occ", occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
